mem_seq: RTL and testbench

MEM_SEQ -- requirements
Module: mem_seq

---
 rtl/core_pkg.sv | 20 ++
 rtl/mem_seq_if.sv | 20 ++
 rtl/mem_seq_wait_timer.sv | 37 +++
 rtl/mem_seq.sv | 148 ++++++++++++++
 tb/tb_mem_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the memory sequencer: state encoding and default timeout.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    ERR   = 3'd5
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // States in which the sequencer owns the shared memory port.
  function automatic logic is_bus_state(input state_e s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/mem_seq_if.sv
// Single shared memory port between the sequencer (master) and memory (slave).
interface mem_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_seq_wait_timer.sv
// Wait-cycle counter for one memory transaction; flags the wait cycle that
// would bring the count to TIMEOUT.
module wait_timer
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned   CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear on transaction entry, otherwise count unanswered cycles.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
    expired = tick && (count_q == LAST);
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/mem_seq.sv
// Multi-cycle fetch / execute / memory / writeback sequencer sharing one
// memory port, with wait timeout, cycle and retired-instruction counters.
module mem_seq
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             ex_ren,
  input  logic             ex_wen,
  input  logic [29:0]      ex_addr,
  input  logic [31:0]      ex_wdata,
  input  logic [3:0]       ex_mask,
  mem_seq_if.master        mem,
  output logic [31:0]      inst,
  output logic [31:0]      ld_data,
  output logic             pc_we,
  output logic             rf_we,
  output logic             err,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      instret_cnt
);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wen_q, wen_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  logic bus_active, handshake;
  logic wait_clear, wait_tick, wait_expired;
  logic pc_unused;

  assign pc_unused  = ^pc[1:0];
  assign bus_active = is_bus_state(state_q);
  assign handshake  = bus_active && mem.mem_ready;
  assign wait_tick  = bus_active && !mem.mem_ready;
  assign wait_clear = is_bus_state(state_d) && (state_d != state_q);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .tick    (wait_tick),
    .expired (wait_expired)
  );

  // Next-state and datapath capture; a handshake always beats timer expiry.
  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    ld_data_d = ld_data_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    wen_d     = wen_q;
    instret_d = instret_q;
    cycle_d   = cycle_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (handshake) begin
          inst_d  = mem.mem_rdata;
          state_d = EXEC;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      EXEC: begin
        addr_d  = ex_addr;
        wdata_d = ex_wdata;
        mask_d  = ex_mask;
        wen_d   = ex_wen;
        state_d = (ex_ren || ex_wen) ? MEM : WB;
      end
      MEM: begin
        if (handshake) begin
          if (!wen_q) ld_data_d = mem.mem_rdata;
          state_d = WB;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      WB: begin
        instret_d = instret_q + 32'd1;
        state_d   = FETCH;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && (state_q != ERR)) cycle_d = cycle_q + 32'd1;
  end

  // Memory port and strobes decode purely from state so reset clears them at once.
  always_comb begin
    mem.mem_req   = bus_active;
    mem.mem_we    = (state_q == MEM) && wen_q;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_mask  = '0;
    if (state_q == FETCH) begin
      mem.mem_addr = pc[31:2];
    end else if (state_q == MEM) begin
      mem.mem_addr  = addr_q;
      mem.mem_wdata = wdata_q;
      mem.mem_mask  = mask_q;
    end
    pc_we       = (state_q == WB);
    rf_we       = (state_q == WB);
    err         = (state_q == ERR);
    inst        = inst_q;
    ld_data     = ld_data_q;
    cycle_cnt   = cycle_q;
    instret_cnt = instret_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      ld_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      wen_q     <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      ld_data_q <= ld_data_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      wen_q     <= wen_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq: each instruction is expanded into a per-cycle
// list of expected port values plus the memory response for that cycle.
module tb_mem_seq;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0;
  logic        ex_ren = 1'b0, ex_wen = 1'b0;
  logic [29:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [3:0]  ex_mask = '0;
  logic [31:0] inst, ld_data, cycle_cnt, instret_cnt;
  logic        pc_we, rf_we, err;

  mem_seq_if bus ();

  mem_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ex_ren(ex_ren), .ex_wen(ex_wen),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_mask(ex_mask), .mem(bus),
    .inst(inst), .ld_data(ld_data), .pc_we(pc_we), .rf_we(rf_we), .err(err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit req, we, commit, is_err, cnt, cap_inst, cap_ld, first, rst_mid, force_ir;
    logic [29:0] addr;  logic [31:0] wdata;  logic [3:0] mask;
    bit ready;          logic [31:0] rdata;  logic [31:0] pc;
    bit e_ren, e_wen;   logic [29:0] e_addr; logic [31:0] e_wdata; logic [3:0] e_mask;
    int lit_now, lit_after;
  } cyc_t;

  typedef struct {
    logic [31:0] pc, iw; bit ren, wen; logic [29:0] ea; logic [31:0] wd; logic [3:0] mk;
    int unsigned fwait, mwait; logic [31:0] rd; int lf, lm, lw; bit fi;
  } instr_t;

  cyc_t cur;
  cyc_t sched[$];
  bit   have_cur = 0, chk_en = 0;
  int   n_vec = 0, n_bad = 0;
  int   ccount = 0, commit_at = 0, st_hs = 0;
  logic [31:0] exp_inst = '0, exp_ld = '0, exp_cycle = '0, exp_instret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic lcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    check(name, act, exp);
  endtask

  function automatic instr_t mk(input logic [31:0] p, iw, input bit ren, wen,
                                input logic [29:0] ea, input logic [31:0] wd, input logic [3:0] m,
                                input int unsigned fw, mw, input logic [31:0] rd,
                                input int lf, lm, lw, input bit fi);
    instr_t t;
    t.pc = p; t.iw = iw; t.ren = ren; t.wen = wen; t.ea = ea; t.wd = wd; t.mk = m;
    t.fwait = fw; t.mwait = mw; t.rd = rd; t.lf = lf; t.lm = lm; t.lw = lw; t.fi = fi;
    return t;
  endfunction

  // A cycle with the port idle; ready is asserted to show it is ignored, and
  // the exu inputs carry junk outside EXEC.
  function automatic cyc_t blank(input logic [31:0] p);
    cyc_t c;
    c = '{default: '0};
    c.pc = p; c.ready = 1'b1; c.rdata = 32'hA5A5_0000;
    c.e_ren = 1'b1; c.e_wen = 1'b1; c.e_addr = 30'h3FFF_FFFF;
    c.e_wdata = 32'hFFFF_FFFF; c.e_mask = 4'hF;
    return c;
  endfunction

  task automatic plan_idle();
    sched.push_back(blank(32'h8000_0000));
  endtask

  task automatic plan_instr(input instr_t t);
    cyc_t c;
    for (int unsigned i = 0; i <= t.fwait; i++) begin
      c = blank(t.pc);
      c.req = 1; c.addr = t.pc[31:2]; c.cnt = 1;
      c.ready = (i == t.fwait); c.rdata = (i == t.fwait) ? t.iw : (32'hBAD0_0000 | i);
      c.cap_inst = (i == t.fwait); c.first = (i == 0); c.force_ir = (i == 0) && t.fi;
      c.lit_now = (i == 0) ? t.lf : 0;
      sched.push_back(c);
    end
    c = blank(t.pc);
    c.cnt = 1; c.e_ren = t.ren; c.e_wen = t.wen; c.e_addr = t.ea; c.e_wdata = t.wd; c.e_mask = t.mk;
    sched.push_back(c);
    if (t.ren || t.wen) begin
      for (int unsigned i = 0; i <= t.mwait; i++) begin
        c = blank(t.pc);
        c.req = 1; c.we = t.wen; c.addr = t.ea; c.wdata = t.wd; c.mask = t.mk; c.cnt = 1;
        c.ready = (i == t.mwait); c.rdata = (i == t.mwait) ? t.rd : (32'h0BAD_0000 | i);
        c.cap_ld = (i == t.mwait) && !t.wen; c.lit_now = (i == t.mwait) ? t.lm : 0;
        sched.push_back(c);
      end
    end
    c = blank(t.pc);
    c.commit = 1; c.cnt = 1; c.lit_after = t.lw;
    sched.push_back(c);
  endtask

  task automatic plan_timeout(input logic [31:0] p, input int unsigned nerr);
    cyc_t c;
    for (int unsigned i = 0; i < TO; i++) begin
      c = blank(p);
      c.req = 1; c.addr = p[31:2]; c.cnt = 1; c.ready = 0; c.first = (i == 0);
      sched.push_back(c);
    end
    for (int unsigned i = 0; i < nerr; i++) begin
      c = blank(p);
      c.is_err = 1; c.lit_after = (i == nerr - 1) ? 6 : 0;
      sched.push_back(c);
    end
  endtask

  task automatic reset_checks(input string tag);
    lcheck({tag, "_ctl"}, {26'd0, bus.mem_req, bus.mem_we, pc_we, rf_we, err, 1'b0}, 32'd0);
    lcheck({tag, "_addr"}, {2'b00, bus.mem_addr}, 32'd0);
    lcheck({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    lcheck({tag, "_mask"}, {28'd0, bus.mem_mask}, 32'd0);
    lcheck({tag, "_inst"}, inst, 32'd0);
    lcheck({tag, "_ld"}, ld_data, 32'd0);
    lcheck({tag, "_cyc"}, cycle_cnt, 32'd0);
    lcheck({tag, "_ret"}, instret_cnt, 32'd0);
  endtask

  task automatic lit_now(input int id);
    case (id)
      1: begin
        lcheck("fetch_addr", {2'b00, bus.mem_addr}, 32'h2000_0000);
        lcheck("fetch_req", {31'd0, bus.mem_req}, 32'd1);
      end
      2: begin
        lcheck("lw_we", {31'd0, bus.mem_we}, 32'd0);
        lcheck("lw_addr", {2'b00, bus.mem_addr}, 32'h2000_0004);
      end
      3: begin
        lcheck("sb_we", {31'd0, bus.mem_we}, 32'd1);
        lcheck("sb_mask", {28'd0, bus.mem_mask}, 32'd4);
        lcheck("sb_wdata", bus.mem_wdata, 32'h00AB_0000);
      end
      default: ;
    endcase
  endtask

  task automatic lit_after(input int id);
    case (id)
      1: begin
        lcheck("addi_instret", instret_cnt, 32'd1);
        lcheck("addi_inst", inst, 32'h0010_0093);
        lcheck("addi_commit_cycle", commit_at, 32'd3);
        lcheck("addi_cycle_cnt", cycle_cnt, 32'd3);
      end
      2: begin
        lcheck("lw_ld_data", ld_data, 32'hDEAD_BEEF);
        lcheck("lw_commit_cycle", commit_at, 32'd6);
      end
      3: begin
        lcheck("sb_store_hs", st_hs, 32'd1);
        lcheck("sb_commit_cycle", commit_at, 32'd4);
        lcheck("sb_ld_kept", ld_data, 32'hDEAD_BEEF);
      end
      4: lcheck("both_ld_kept", ld_data, 32'hDEAD_BEEF);
      5: lcheck("instret_wrap", instret_cnt, 32'd0);
      6: begin
        lcheck("err_flag", {31'd0, err}, 32'd1);
        lcheck("err_req", {31'd0, bus.mem_req}, 32'd0);
      end
      default: ;
    endcase
  endtask

  // Register-visible effects of the cycle that just closed.
  task automatic model_update(input cyc_t c);
    if (c.rst_mid) begin
      exp_inst = '0; exp_ld = '0; exp_cycle = '0; exp_instret = '0;
    end else begin
      if (c.cap_inst) exp_inst = c.rdata;
      if (c.cap_ld)   exp_ld = c.rdata;
      if (c.commit)   exp_instret = exp_instret + 32'd1;
      if (c.cnt)      exp_cycle = exp_cycle + 32'd1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (have_cur) begin
      model_update(cur);
      lit_after(cur.lit_after);
    end
    rst = 1'b0;
    cur = sched.pop_front();
    have_cur = 1;
    pc = cur.pc; ex_ren = cur.e_ren; ex_wen = cur.e_wen;
    ex_addr = cur.e_addr; ex_wdata = cur.e_wdata; ex_mask = cur.e_mask;
    bus.mem_ready = cur.ready; bus.mem_rdata = cur.rdata;
    chk_en = !cur.rst_mid;
    if (cur.force_ir) begin
      force dut.instret_q = 32'hFFFF_FFFF;
      exp_instret = 32'hFFFF_FFFF;
      #1 release dut.instret_q;
    end
    if (cur.lit_now != 0) begin
      #1 lit_now(cur.lit_now);
    end
    if (cur.rst_mid) begin
      #1 rst = 1'b1;
      #1 reset_checks("rst_mid");
    end
  endtask

  task automatic run();
    while (sched.size() > 0) step();
  endtask

  // Per-cycle comparison against the expected cycle record.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (cur.first) begin
        ccount = 1; st_hs = 0;
      end else begin
        ccount++;
      end
      if (pc_we) commit_at = ccount;
      if (bus.mem_req && bus.mem_ready && bus.mem_we) st_hs++;
      check("mem_req", {31'd0, bus.mem_req}, {31'd0, cur.req});
      check("mem_we", {31'd0, bus.mem_we}, {31'd0, cur.we});
      check("mem_addr", {2'b00, bus.mem_addr}, {2'b00, cur.addr});
      check("mem_wdata", bus.mem_wdata, cur.wdata);
      check("mem_mask", {28'd0, bus.mem_mask}, {28'd0, cur.mask});
      check("pc_we", {31'd0, pc_we}, {31'd0, cur.commit});
      check("rf_we", {31'd0, rf_we}, {31'd0, cur.commit});
      check("err", {31'd0, err}, {31'd0, cur.is_err});
      check("inst", inst, exp_inst);
      check("ld_data", ld_data, exp_ld);
      check("cycle_cnt", cycle_cnt, exp_cycle);
      check("instret_cnt", instret_cnt, exp_instret);
    end
  end

  initial begin
    cyc_t c;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    #1 rst = 1'b1;
    #2 reset_checks("por");

    plan_idle();
    plan_instr(mk(32'h8000_0000, 32'h0010_0093, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0, 32'h0, 1, 0, 1, 0));
    run();
    plan_instr(mk(32'h8000_0004, 32'h0040_2083, 1, 0, 30'h2000_0004, 32'h1111_2222, 4'hF, 0, 2,
                  32'hDEAD_BEEF, 0, 2, 2, 0));
    run();
    plan_instr(mk(32'h8000_0008, 32'h0010_0123, 0, 1, 30'h0000_0010, 32'h00AB_0000, 4'b0100, 0, 0,
                  32'h0, 0, 3, 3, 0));
    run();
    plan_instr(mk(32'h8000_000C, 32'h0000_0000, 1, 1, 30'h0000_0015, 32'h1234_5678, 4'hF, 0, 1,
                  32'hCAFE_F00D, 0, 0, 4, 0));
    run();
    // Fetch answered on the last allowed wait cycle; instret preset to wrap.
    plan_instr(mk(32'h8000_0010, 32'h0020_0113, 0, 0, 30'h0, 32'h0, 4'h0, TO - 1, 0, 32'h0, 0, 0, 5, 1));
    run();
    // Load interrupted by reset during its memory wait.
    plan_instr(mk(32'h8000_0014, 32'h1000_2083, 1, 0, 30'h0000_0100, 32'h0, 4'hF, 0, 3,
                  32'h7777_7777, 0, 0, 0, 0));
    c = sched[3]; c.rst_mid = 1; sched[3] = c;
    while (sched.size() > 4) sched.delete(sched.size() - 1);
    plan_idle();
    plan_instr(mk(32'h8000_0040, 32'h0030_0193, 0, 0, 30'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0, 0, 0, 0));
    run();
    plan_timeout(32'h8000_0044, 5);
    run();

    @(posedge clk); #1;
    model_update(cur);
    lit_after(cur.lit_after);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
